// File: rtl/cla_mult_seq_ctrl.sv
// Iterative shift-add multiplier. One N-bit carry-lookahead adder is reused
// once per multiplier bit, and valid/ready handshakes sit on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// RUN   | one add/shift step per cycle, M cycles in total
// DONE  | product presented; held until out_ready

module cla_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

module cla_mult_seq_ctrl #(
    parameter int N = 32,
    parameter int M = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multicand,
    input  logic [M-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] product,
    output logic           busy
);
    localparam int CW = $clog2(M + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(M);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  mcand_q;
    logic [N-1:0]  acc_hi;
    logic [M-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    logic [N-1:0]  add_in1;
    logic [N-1:0]  add_sum;
    logic          add_c;

    // Multiplier LSB gates the partial product; the adder carry is kept as the new top bit.
    assign add_in1 = acc_lo[0] ? mcand_q : '0;

    cla_adder #(.W(N)) u_adder (
        .a    (add_in1),
        .b    (acc_hi),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand_q <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= multicand;
                        acc_hi  <= '0;
                        acc_lo  <= multiplier;
                        cnt     <= CNT_INIT;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= {add_c, add_sum[N-1:1]};
                    acc_lo <= {add_sum[0], acc_lo[M-1:1]};
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = {acc_hi, acc_lo};
endmodule

// File: tb/tb_cla_mult_seq_ctrl.sv
// Scoreboard bench for cla_mult_seq_ctrl: directed corner cases followed by a
// randomized handshake regression checked against a plain multiply.

module tb_cla_mult_seq_ctrl;
    localparam int N = 16;
    localparam int M = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   multicand = '0;
    logic [M-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N+M-1:0] product;
    logic           busy;

    cla_mult_seq_ctrl #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .multicand  (multicand),
        .multiplier (multiplier),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N+M-1:0] exp;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_push = 0;
    int n_pop = 0;
    int n_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: observes accepts (pushes reference product) and output handshakes (pops and compares).
    initial begin : monitor
        logic           pv;
        logic           pr;
        logic [N+M-1:0] pp;
        exp_t           e;
        pv = 1'b0;
        pr = 1'b0;
        pp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            check("busy", busy, q.size() != 0);
            check("in_ready", in_ready, q.size() == 0);
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1);
                check("hold_product", product, pp);
            end
            if (out_valid && !pv) begin
                if (q.size() == 0) timeout("latency_no_expect");
                else check("latency", cyc - q[0].cyc, M + 1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output actual=%0d expected=none", product);
                end else begin
                    e = q.pop_front();
                    check("product", product, e.exp);
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                e.exp = (N+M)'(multicand) * (N+M)'(multiplier);
                e.cyc = cyc;
                q.push_back(e);
                n_push++;
            end
            pv = out_valid;
            pr = out_ready;
            pp = product;
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((q.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [M-1:0] b, input int stall, input int rst_at);
        int k;
        @(posedge clk);
        #1;
        multicand  = a;
        multiplier = b;
        in_valid   = 1'b1;
        out_ready  = (stall == 0);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeout("accept");
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        multicand  = N'($urandom);
        multiplier = M'($urandom);
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_product", product, 0);
            n_flush += q.size();
            q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
        end
        if (stall > 0) begin
            k = 0;
            while (!out_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) timeout("out_valid");
            repeat (stall) begin
                @(posedge clk);
                #1;
                in_valid = 1'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        wait_idle("drain_op");
    endtask

    initial begin
        int k;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_product", product, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op(16'd13, 8'd11, 0, 0);
        do_op(16'd255, 8'd255, 0, 0);
        do_op(16'hFFFF, 8'hFF, 0, 0);
        do_op(16'd0, 8'd200, 0, 0);
        do_op(16'd1, 8'd255, 0, 0);
        do_op(16'd100, 8'd200, 5, 0);
        do_op(16'd7, 8'd9, 0, 4);
        check("no_output_after_reset", out_valid, 0);
        do_op(16'd3, 8'd5, 0, 0);

        k = 0;
        while (n_push < 1008 && k < 40000) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       multicand = '1;
                1:       multicand = '0;
                default: multicand = N'($urandom);
            endcase
            multiplier = ($urandom_range(0, 7) == 0) ? '1 : M'($urandom);
            k++;
        end
        if (k >= 40000) timeout("random_phase");
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("drain_random");
        check("in_order_count", n_pop, n_push - n_flush);
        check("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_mult_seq_ctrl.md
Name: cla_mult_seq_ctrl

Overview:
Iterative shift-add multiplier controller. It time-shares a single N-bit CLA_Adder instance over M cycles instead of the M-1 adder array used in the fully combinational multiplier. It accepts an operand pair over a valid/ready handshake, sequences the adder one multiplier bit per cycle, and presents the N+M-bit product over a valid/ready handshake. It is intended for area-constrained paths where a latency of M+1 cycles is acceptable.

Parameters:
N, 32, multiplicand width (also the width of the shared CLA_Adder; must be >= 2)
M, 32, multiplier width (iteration count; must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
multicand  input  N  multiplicand, unsigned
multiplier  input  M  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  N+M  unsigned product
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, RUN, DONE. Encoding is free.
- Internal registers:
  - mcand_q [N-1:0]
  - acc_hi [N-1:0]
  - acc_lo [M-1:0]
  - cnt, width clog2(M+1)
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - acc_hi, acc_lo, mcand_q, cnt = 0, so product reads 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: mcand_q<=multicand, acc_hi<=0, acc_lo<=multiplier, cnt<=M, then go to RUN.
  - With no in_valid, all registers hold.
- RUN (in_ready=0):
  - The adder gets in1=mcand_q if acc_lo[0] else 0, in2=acc_hi, cin=0. It returns sum s[N-1:0] and carry c.
  - Update: acc_hi<={c,s[N-1:1]}, acc_lo<={s[0],acc_lo[M-1:1]}, cnt<=cnt-1.
  - When cnt==1 the update still happens and the state moves to DONE.
  - RUN lasts exactly M cycles. There is no early termination on zero operands.
- DONE:
  - out_valid=1, product={acc_hi,acc_lo}.
  - On out_valid&out_ready, go to IDLE next cycle with out_valid=0. The product register holds its last value until the next accept.
  - While out_ready=0, product and out_valid hold stable (no drop, no change).
- Latency: operands accepted at edge t; out_valid first high in the cycle after edge t+M. That is M+1 clocks from acceptance, with a minimum initiation interval of M+2 cycles.
- in_ready is high only in IDLE. Operands offered in RUN or DONE are ignored; the upstream must hold them.
- A new accept cannot happen in the same cycle as the output handshake.
- Arithmetic: unsigned only. The carry out of the adder is never lost; it becomes acc_hi[N-1].
- Full scale: (2^N-1)(2^M-1) fits in N+M bits with no overflow.
- Reset mid-operation (RUN or DONE): all outputs return immediately to reset values. The in-flight result is discarded and no out_valid is produced for it.
- X-safety: multicand and multiplier are sampled only on an accept. Input values are don't-care at all other times.
- busy = (state != IDLE).

Test Plan:
- N=M=8, multicand=13, multiplier=11, out_ready=1 -> out_valid rises exactly 9 cycles after accept, product=143 for one cycle, then IDLE.
- N=M=8, 255x255 -> product=65025 (0xFE01), confirming the carry propagates into the top bit.
- N=M=8: 0x200 -> product=0; then 1x255 -> product=255. Both take the full 8 RUN cycles.
- Backpressure: 100x200 with out_ready=0 for 5 cycles after out_valid -> product holds 20000 and out_valid stays high. in_ready stays 0 and in_valid pulses in that window are ignored. out_ready=1 completes the handshake, and in_ready=1 the next cycle.
- Reset mid-op: assert rst_n=0 at RUN cycle 4 of 7x9 -> in_ready=1, out_valid=0, product=0 asynchronously. After release, 3x5 yields 15 with no stale output.
- N=16, M=8 random regression: 1000 back-to-back operand pairs with random in_valid and out_ready -> every product matches the reference multiply, in order, with none lost or duplicated.
